conv_pool_rx: RTL

- Receiving end of the convolution result stream: consumes the signed `out_valid`/`data_out` stream produced by the 3x3 conv stage (26x26 results per 28x28 image, row-major, with idle gaps between rows).
- Applies optional ReLU and 2x2 stride-2 max pooling.
- Emits a 13x13 pooled feature map as a valid-qualified stream with a last-of-frame marker. Sits directly after the conv stage, ahead of the next layer.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_pool_rx_line_buf.sv | 40 ++++
 rtl/conv_pool_rx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg: shared constants for the convolution front end and its consumers.
//   CONV_DW            signed width of conv results
//   IMG_W / IMG_H      input image size
//   CONV_OUT_W / _H    valid-conv result map size (image minus 3x3 kernel apron)
//   max2()             signed maximum of two CONV_DW-bit samples
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int CONV_DW    = 33;
    localparam int IMG_W      = 28;
    localparam int IMG_H      = 28;
    localparam int CONV_OUT_W = 26;
    localparam int CONV_OUT_H = 26;

    // Signed compare at full width; no growth, ties return either operand.
    function automatic logic signed [CONV_DW-1:0] max2(
        input logic signed [CONV_DW-1:0] a,
        input logic signed [CONV_DW-1:0] b
    );
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/conv_pool_rx_line_buf.sv
// -----------------------------------------------------------------------------
// pool_line_buf: one row of horizontally pooled pairs, kept from the even input
// row until the matching odd row arrives.
//   clk    clock
//   we     write enable (sync)
//   waddr  write index (column pair)
//   wdata  value written
//   raddr  read index (column pair)
//   rdata  combinational read data
// Contents carry no reset: every entry is written on an even row before it is
// read on the following odd row.
// -----------------------------------------------------------------------------
module pool_line_buf #(
    parameter int DEPTH = 13,
    parameter int DW    = 33,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [0:DEPTH-1];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Combinational read port.
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/conv_pool_rx.sv
// -----------------------------------------------------------------------------
// conv_pool_rx: receives the row-major conv result stream, applies optional
// ReLU and 2x2 stride-2 max pooling, and emits the pooled map as a valid-
// qualified stream with a last-of-frame marker.
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   clr        synchronous frame abort (drops the sample presented with it)
//   in_valid   input qualifier, gaps allowed
//   in_data    signed conv result
//   out_valid  one-cycle pulse per pooled sample
//   out_data   pooled value, zero when out_valid is low
//   out_last   marks the final pooled sample of a frame
//   busy       high from first accepted sample until the out_last cycle
// -----------------------------------------------------------------------------
module conv_pool_rx
    import conv_pkg::*;
#(
    parameter int DW      = CONV_DW,
    parameter int IN_W    = CONV_OUT_W,
    parameter int IN_H    = CONV_OUT_H,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int HALF_W = IN_W / 2;
    localparam int CW     = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int RW     = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic signed [DW-1:0] hold_q, hold_d;
    logic                 out_valid_q, out_valid_d;
    logic signed [DW-1:0] out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic                 busy_q, busy_d;

    logic                 accept_s;
    logic                 col_last_s;
    logic                 row_last_s;
    logic signed [DW-1:0] v_s;
    logic signed [DW-1:0] h_s;
    logic signed [DW-1:0] p_s;
    logic [DW-1:0]        lb_rdata_s;
    logic [AW-1:0]        lb_addr_s;
    logic                 lb_we_s;
    logic                 pool_fire_s;

    // Input qualification, ReLU and the horizontal/vertical max datapath.
    always_comb begin
        // A sample presented alongside clr is discarded.
        accept_s    = in_valid & ~clr;
        col_last_s  = (col_q == CW'(IN_W - 1));
        row_last_s  = (row_q == RW'(IN_H - 1));
        if (RELU_EN && in_data[DW-1]) begin
            v_s = {DW{1'b0}};
        end else begin
            v_s = in_data;
        end
        h_s         = max2(hold_q, v_s);
        p_s         = max2($signed(lb_rdata_s), h_s);
        lb_addr_s   = AW'(col_q >> 1);
        // Even rows park their horizontal max; odd rows complete the 2x2 window.
        lb_we_s     = accept_s & ~row_q[0] & col_q[0];
        pool_fire_s = accept_s &  row_q[0] & col_q[0];
    end

    pool_line_buf #(
        .DEPTH (HALF_W),
        .DW    (DW),
        .AW    (AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we_s),
        .waddr (lb_addr_s),
        .wdata (h_s),
        .raddr (lb_addr_s),
        .rdata (lb_rdata_s)
    );

    // Raster position counters and the even-column hold register.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        hold_d = hold_q;
        if (clr) begin
            col_d  = {CW{1'b0}};
            row_d  = {RW{1'b0}};
            hold_d = {DW{1'b0}};
        end else if (accept_s) begin
            if (col_last_s) begin
                col_d = {CW{1'b0}};
                if (row_last_s) begin
                    row_d = {RW{1'b0}};
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
                row_d = row_q;
            end
            if (!col_q[0]) begin
                hold_d = v_s;
            end else begin
                hold_d = hold_q;
            end
        end else begin
            col_d  = col_q;
            row_d  = row_q;
            hold_d = hold_q;
        end
    end

    // Next output registers and frame-activity flag.
    always_comb begin
        out_valid_d = pool_fire_s;
        out_last_d  = pool_fire_s & row_last_s & col_last_s;
        if (pool_fire_s) begin
            out_data_d = p_s;
        end else begin
            out_data_d = {DW{1'b0}};
        end
        // busy covers the out_last cycle itself, then drops unless a new
        // frame has already started on that same edge.
        if (clr) begin
            busy_d = 1'b0;
        end else if (accept_s) begin
            busy_d = 1'b1;
        end else if (out_last_q) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= {CW{1'b0}};
            row_q       <= {RW{1'b0}};
            hold_q      <= {DW{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {DW{1'b0}};
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule
